// File: rtl/requantize_stream.sv
`default_nettype none
// ============================================================================
// Module   : requantize_stream
// Brief    : Per-channel scale, rounding shift, zero point and saturation of a
//            signed 32-bit stream down to OUT_W bits, with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module requantize_stream #(
    parameter int NUM_CH  = 16,
    parameter int SCALE_W = 16,
    parameter int OUT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    input  logic                      scale_we,
    input  logic [$clog2(NUM_CH)-1:0] scale_addr,
    input  logic [SCALE_W-1:0]        scale_wdata,
    input  logic [4:0]                shift,
    input  logic [OUT_W-1:0]          zero_point,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_last,
    output logic [15:0]               sat_count
);

    localparam int c_CH_W = $clog2(NUM_CH);
    localparam int c_PW   = 32 + SCALE_W + 1;
    localparam int c_RW   = c_PW + 1;
    localparam int c_VW   = c_RW + 1;

    localparam logic signed [c_VW-1:0] c_OUT_MAX = {{(c_VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_VW-1:0] c_OUT_MIN = {{(c_VW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                      w_adv;
    logic                      w_accept;

    logic [SCALE_W-1:0]        r_scale [NUM_CH];
    logic [c_CH_W-1:0]         r_ch;

    logic                      r_s1_valid;
    logic signed [31:0]        r_s1_data;
    logic [c_CH_W-1:0]         r_s1_ch;
    logic [SCALE_W-1:0]        r_s1_scale;

    logic                      r_s2_valid;
    logic signed [c_PW-1:0]    r_s2_prod;
    logic [c_CH_W-1:0]         r_s2_ch;

    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_data;
    logic                      r_out_last;
    logic [15:0]               r_sat_count;

    logic signed [c_PW-1:0]    w_mul_a;
    logic signed [c_PW-1:0]    w_mul_b;
    logic signed [c_RW-1:0]    w_prod_ext;
    logic signed [c_RW-1:0]    w_bias;
    logic signed [c_RW-1:0]    w_sum;
    logic signed [c_RW-1:0]    w_rounded;
    logic signed [c_VW-1:0]    w_value;
    logic [OUT_W-1:0]          w_clamped;
    logic                      w_sat;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv && !clear;
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sat_count = r_sat_count;

    // Table survives clear; S1 samples the pre-write value on a same-cycle hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_scale[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (scale_we && (scale_addr == c_CH_W'(i))) begin
                    r_scale[i] <= scale_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch <= '0;
        end else if (clear) begin
            r_ch <= '0;
        end else if (w_accept) begin
            if (r_ch == c_CH_W'(NUM_CH - 1)) begin
                r_ch <= '0;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ch    <= '0;
            r_s1_scale <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data  <= in_data;
                r_s1_ch    <= r_ch;
                r_s1_scale <= r_scale[r_ch];
            end
        end
    end

    // Both operands widened to the full product width so nothing is truncated.
    assign w_mul_a = {{(c_PW-32){r_s1_data[31]}}, r_s1_data};
    assign w_mul_b = {{(c_PW-SCALE_W){1'b0}}, r_s1_scale};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_ch    <= '0;
        end else if (clear) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod <= w_mul_a * w_mul_b;
                r_s2_ch   <= r_s1_ch;
            end
        end
    end

    assign w_prod_ext = {r_s2_prod[c_PW-1], r_s2_prod};
    assign w_bias     = (shift == 5'd0) ? '0 : (c_RW'(1) << (shift - 5'd1));
    assign w_sum      = w_prod_ext + w_bias;
    assign w_rounded  = w_sum >>> shift;
    assign w_value    = {w_rounded[c_RW-1], w_rounded}
                      + {{(c_VW-OUT_W){zero_point[OUT_W-1]}}, zero_point};

    always_comb begin
        w_sat     = 1'b0;
        w_clamped = w_value[OUT_W-1:0];
        if (w_value > c_OUT_MAX) begin
            w_sat     = 1'b1;
            w_clamped = c_OUT_MAX[OUT_W-1:0];
        end else if (w_value < c_OUT_MIN) begin
            w_sat     = 1'b1;
            w_clamped = c_OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_sat_count <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_sat_count <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data <= w_clamped;
                r_out_last <= (r_s2_ch == c_CH_W'(NUM_CH - 1));
                if (w_sat && (r_sat_count != 16'hFFFF)) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_requantize_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_requantize_stream
// Brief    : Randomized and directed scoreboard bench for requantize_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_requantize_stream;

    localparam int NUM_CH  = 16;
    localparam int SCALE_W = 16;
    localparam int OUT_W   = 8;
    localparam longint OMAX = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OUT_W - 1));

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clear = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_data = '0;
    logic               scale_we = 1'b0;
    logic [3:0]         scale_addr = '0;
    logic [SCALE_W-1:0] scale_wdata = '0;
    logic [4:0]         shift = '0;
    logic [OUT_W-1:0]   zero_point = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [OUT_W-1:0]   out_data;
    logic               out_last;
    logic [15:0]        sat_count;

    requantize_stream #(.NUM_CH(NUM_CH), .SCALE_W(SCALE_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .scale_we(scale_we), .scale_addr(scale_addr), .scale_wdata(scale_wdata),
        .shift(shift), .zero_point(zero_point),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct { int data; bit last; bit sat; int acc; bit lat; } exp_t;
    typedef struct { int data; bit last; } got_t;

    exp_t   q[$];
    got_t   got[$];
    int     m_scale [NUM_CH];
    int     m_ch = 0;
    int     m_sat = 0;
    int     ncyc = 0;
    bit     lat_mode = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Round half up expressed as floor(x + 0.5) on an exact real value.
    function automatic void ref_calc(input int din, input int sc, input int sh, input int zp,
                                     output int o, output bit s);
        longint p, r, v;
        real    x;
        p = longint'(din) * longint'(sc);
        x = real'(p) / (2.0 ** sh);
        r = (sh == 0) ? p : longint'($floor(x + 0.5));
        v = r + longint'(zp);
        s = 1'b1;
        if (v > OMAX)      o = int'(OMAX);
        else if (v < OMIN) o = int'(OMIN);
        else begin
            o = int'(v);
            s = 1'b0;
        end
    endfunction

    // Monitor / scoreboard on the falling edge.
    initial begin
        bit       prev_stall;
        logic [OUT_W-1:0] prev_data;
        logic     prev_last;
        bit       exp_rdy;
        exp_t     e;
        got_t     g;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                q.delete();
                m_ch = 0;
                m_sat = 0;
                foreach (m_scale[i]) m_scale[i] = 0;
                prev_stall = 0;
            end else begin
                exp_rdy = !(out_valid && !out_ready) && !clear;
                chk(in_ready === exp_rdy, "in_ready", in_ready, exp_rdy);
                if (prev_stall) begin
                    chk(out_valid === 1'b1, "stall_valid", out_valid, 1);
                    chk(out_data === prev_data, "stall_data", $signed(out_data), $signed(prev_data));
                    chk(out_last === prev_last, "stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_output", $signed(out_data), 0);
                    end else begin
                        e = q.pop_front();
                        chk(int'($signed(out_data)) == e.data, "out_data", $signed(out_data), e.data);
                        chk(out_last == e.last, "out_last", out_last, e.last);
                        if (e.sat && m_sat < 65535) m_sat++;
                        chk(int'(sat_count) == m_sat, "sat_count", sat_count, m_sat);
                        if (e.lat) chk(ncyc - e.acc == 3, "latency", ncyc - e.acc, 3);
                        g.data = int'($signed(out_data));
                        g.last = out_last;
                        got.push_back(g);
                    end
                end
                prev_stall = out_valid && !out_ready && !clear;
                prev_data  = out_data;
                prev_last  = out_last;
                if (clear) begin
                    q.delete();
                    m_ch = 0;
                    m_sat = 0;
                end else if (in_valid && in_ready) begin
                    ref_calc($signed(in_data), m_scale[m_ch], int'(shift),
                             int'($signed(zero_point)), e.data, e.sat);
                    e.last = (m_ch == NUM_CH - 1);
                    e.acc  = ncyc;
                    e.lat  = lat_mode;
                    q.push_back(e);
                    m_ch = (m_ch + 1) % NUM_CH;
                end
                if (scale_we) m_scale[scale_addr] = int'(scale_wdata);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog_timeout actual=%0t expected=finish", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_scale(input int a, input int v);
        scale_we = 1'b1;
        scale_addr = 4'(a);
        scale_wdata = SCALE_W'(v);
        step();
        scale_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!done) chk(1'b0, "send_timeout", 0, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int k = 0; k < 500 && !idle; k++) begin
            if (q.size() == 0 && !out_valid) idle = 1;
            else step();
        end
        if (!idle) chk(1'b0, "drain_timeout", q.size(), 0);
    endtask

    initial begin
        bit rdone;
        // Reset state
        #23;
        chk(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
        chk(out_data === '0, "rst_out_data", out_data, 0);
        chk(out_last === 1'b0, "rst_out_last", out_last, 0);
        chk(sat_count === 16'd0, "rst_sat_count", sat_count, 0);
        rst = 1'b1;
        step();
        chk(in_ready === 1'b1, "rst_in_ready", in_ready, 1);

        // Basic scaling with latency check
        wr_scale(0, 16'h0040);
        shift = 5'd16;
        zero_point = '0;
        got.delete();
        lat_mode = 1;
        send(32'h0001_0000);
        wait_idle();
        lat_mode = 0;
        chk(got.size() == 1 && got[0].data == 64, "basic_value", got.size() > 0 ? got[0].data : -999, 64);
        chk(got.size() == 1 && got[0].last == 0, "basic_last", got.size() > 0 ? got[0].last : 1, 0);

        // Rounding and zero point
        for (int i = 0; i < NUM_CH; i++) wr_scale(i, 1);
        do_clear();
        got.delete();
        send(32'h0000_8000);
        send(32'hFFFF_8000);
        wait_idle();
        zero_point = 8'(-10);
        send(32'h0001_0000);
        wait_idle();
        chk(got.size() == 3, "round_count", got.size(), 3);
        if (got.size() == 3) begin
            chk(got[0].data == 1, "round_half_pos", got[0].data, 1);
            chk(got[1].data == 0, "round_half_neg", got[1].data, 0);
            chk(got[2].data == -9, "zero_point", got[2].data, -9);
        end

        // Saturation
        zero_point = '0;
        for (int i = 0; i < NUM_CH; i++) wr_scale(i, 16'h0100);
        do_clear();
        got.delete();
        send(32'h0001_0000);
        wait_idle();
        chk(sat_count == 16'd1, "sat_count_1", sat_count, 1);
        send(32'hFFFF_0000);
        wait_idle();
        chk(sat_count == 16'd2, "sat_count_2", sat_count, 2);
        chk(got.size() == 2 && got[0].data == 127, "sat_pos", got.size() > 0 ? got[0].data : -999, 127);
        chk(got.size() == 2 && got[1].data == -128, "sat_neg", got.size() > 1 ? got[1].data : -999, -128);
        for (int n = 0; n < 65600; n++) send(32'h0001_0000);
        wait_idle();
        chk(sat_count == 16'hFFFF, "sat_sticky", sat_count, 16'hFFFF);

        // Channel wrap and last
        for (int i = 0; i < NUM_CH; i++) wr_scale(i, i + 1);
        shift = 5'd0;
        do_clear();
        got.delete();
        for (int n = 0; n < 34; n++) send(32'd1);
        wait_idle();
        chk(got.size() == 34, "wrap_count", got.size(), 34);
        for (int i = 0; i < got.size(); i++) begin
            chk(got[i].data == (i % 16) + 1, "wrap_value", got[i].data, (i % 16) + 1);
            chk(got[i].last == (i == 15 || i == 31), "wrap_last", got[i].last, (i == 15 || i == 31));
        end

        // Clear with 3 in flight, then table hazard on channel 0
        out_ready = 1'b0;
        send(32'd1);
        send(32'd1);
        send(32'd1);
        chk(out_valid === 1'b1, "preclear_valid", out_valid, 1);
        do_clear();
        got.delete();
        for (int k = 0; k < 4; k++) begin
            chk(out_valid === 1'b0, "postclear_valid", out_valid, 0);
            step();
        end
        out_ready = 1'b1;
        scale_we = 1'b1;
        scale_addr = 4'd0;
        scale_wdata = 16'd7;
        send(32'd1);
        scale_we = 1'b0;
        for (int n = 0; n < 16; n++) send(32'd1);
        wait_idle();
        chk(got.size() == 17, "hazard_count", got.size(), 17);
        if (got.size() == 17) begin
            chk(got[0].data == 1, "hazard_old_scale", got[0].data, 1);
            chk(got[1].data == 2, "postclear_ch1", got[1].data, 2);
            chk(got[16].data == 7, "hazard_new_scale", got[16].data, 7);
        end

        // Random backpressure rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_CH; i++) wr_scale(i, int'($urandom_range(0, 65535)));
            shift = 5'($urandom_range(0, 31));
            zero_point = OUT_W'($urandom);
            rdone = 0;
            fork
                begin
                    for (int n = 0; n < 300; n++)
                        send($signed($urandom) >>> $urandom_range(0, 24));
                    rdone = 1;
                end
                begin
                    while (!rdone) begin
                        out_ready = 1'($urandom_range(0, 1));
                        step();
                    end
                    out_ready = 1'b1;
                end
            join
            wait_idle();
        end

        // Asynchronous reset mid-stream
        shift = 5'd0;
        zero_point = '0;
        in_valid = 1'b1;
        in_data = 32'd1;
        for (int k = 0; k < 6; k++) step();
        #2;
        chk(out_valid === 1'b1, "prereset_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk(out_valid === 1'b0, "async_reset_valid", out_valid, 0);
        chk(sat_count === 16'd0, "async_reset_sat", sat_count, 0);
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        step();
        got.delete();
        wr_scale(0, 3);
        wr_scale(1, 9);
        send(32'd5);
        wait_idle();
        chk(got.size() == 1, "postreset_count", got.size(), 1);
        chk(got.size() == 1 && got[0].data == 15, "postreset_ch0", got.size() > 0 ? got[0].data : -999, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
